// File: rtl/block_stream_gen_pkg.sv
// Shared encodings for the block-nesting stream generators: commands, ASCII
// constants, FSM states and per-word letter counts.
package block_stream_gen_pkg;

    localparam logic [1:0] CMD_BEGIN  = 2'b00;
    localparam logic [1:0] CMD_END    = 2'b01;
    localparam logic [1:0] CMD_FILLER = 2'b10;
    localparam logic [1:0] CMD_NOP    = 2'b11;

    localparam logic [7:0] ASCII_SPACE    = 8'h20;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

    localparam logic [2:0] LEN_BEGIN  = 3'd5;
    localparam logic [2:0] LEN_END    = 3'd3;
    localparam logic [2:0] LEN_FILLER = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WORD = 2'd1,
        ST_SEP  = 2'd2
    } state_t;

    // Letter count of a word, trailing space excluded.
    function automatic logic [2:0] word_len(input logic [1:0] c);
        case (c)
            CMD_BEGIN:  word_len = LEN_BEGIN;
            CMD_END:    word_len = LEN_END;
            default:    word_len = LEN_FILLER;
        endcase
    endfunction

endpackage

// File: rtl/block_stream_gen_word_rom.sv
// Letter lookup: (command, letter index, case) -> ASCII byte; purely combinational.
// Out-of-range indices and NOP return a space.
module block_word_rom
    import block_stream_gen_pkg::*;
(
    input  logic [1:0] i_cmd,
    input  logic [2:0] i_idx,
    input  logic       i_upper,
    output logic [7:0] o_char
);

    logic [7:0] w_lower;

    always_comb begin
        w_lower = ASCII_SPACE;
        case (i_cmd)
            CMD_BEGIN: begin
                case (i_idx)
                    3'd0:    w_lower = "b";
                    3'd1:    w_lower = "e";
                    3'd2:    w_lower = "g";
                    3'd3:    w_lower = "i";
                    3'd4:    w_lower = "n";
                    default: w_lower = ASCII_SPACE;
                endcase
            end
            CMD_END: begin
                case (i_idx)
                    3'd0:    w_lower = "e";
                    3'd1:    w_lower = "n";
                    3'd2:    w_lower = "d";
                    default: w_lower = ASCII_SPACE;
                endcase
            end
            CMD_FILLER: begin
                if (i_idx == 3'd0) w_lower = "x";
            end
            default: w_lower = ASCII_SPACE;
        endcase
    end

    // Space has no case, so it bypasses the offset.
    assign o_char = (i_upper && (w_lower != ASCII_SPACE)) ? (w_lower - ASCII_CASE_OFS) : w_lower;

endmodule

// File: rtl/block_stream_gen.sv
// Serialises BEGIN/END/FILLER commands into a space-separated ASCII stream and
// tracks nesting depth plus a sticky error, so the checker verdict is known here.
module block_stream_gen
    import block_stream_gen_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    input  logic               cmd_upper,
    output logic               cmd_ready,
    output logic               out_valid,
    output logic [7:0]         out_char,
    output logic [DEPTH_W-1:0] depth,
    output logic               err,
    output logic               balanced
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_cmd;
    logic               r_upper;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic [7:0]         r_out_char;
    logic [7:0]         w_out_char_nxt;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err;

    logic               w_accept;
    logic               w_start;
    logic [1:0]         w_rom_cmd;
    logic [2:0]         w_rom_idx;
    logic               w_rom_upper;
    logic [7:0]         w_rom_char;

    assign cmd_ready = (r_state == ST_IDLE) || (r_state == ST_SEP);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_start   = w_accept && (cmd != CMD_NOP);

    // One ROM serves both the first letter of a new word and the next letter of the current one.
    assign w_rom_cmd   = w_accept ? cmd       : r_cmd;
    assign w_rom_idx   = w_accept ? 3'd0      : (r_idx + 3'd1);
    assign w_rom_upper = w_accept ? cmd_upper : r_upper;

    block_word_rom u_rom (
        .i_cmd   (w_rom_cmd),
        .i_idx   (w_rom_idx),
        .i_upper (w_rom_upper),
        .o_char  (w_rom_char)
    );

    always_comb begin
        w_state_nxt     = ST_IDLE;
        w_idx_nxt       = r_idx;
        w_out_valid_nxt = 1'b0;
        w_out_char_nxt  = ASCII_SPACE;
        if (w_start) begin
            w_state_nxt     = ST_WORD;
            w_idx_nxt       = 3'd0;
            w_out_valid_nxt = 1'b1;
            w_out_char_nxt  = w_rom_char;
        end else if (r_state == ST_WORD) begin
            w_out_valid_nxt = 1'b1;
            if (r_idx == (word_len(r_cmd) - 3'd1)) begin
                w_state_nxt    = ST_SEP;
                w_out_char_nxt = ASCII_SPACE;
            end else begin
                w_state_nxt    = ST_WORD;
                w_idx_nxt      = r_idx + 3'd1;
                w_out_char_nxt = w_rom_char;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_cmd       <= CMD_NOP;
            r_upper     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= ASCII_SPACE;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_char  <= w_out_char_nxt;
            if (w_accept) begin
                r_cmd   <= cmd;
                r_upper <= cmd_upper;
            end
        end
    end

    // Depth saturates at both ends; any attempt to cross a limit latches the error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_depth <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            case (cmd)
                CMD_BEGIN: begin
                    if (&r_depth) r_err   <= 1'b1;
                    else          r_depth <= r_depth + 1'b1;
                end
                CMD_END: begin
                    if (r_depth == '0) r_err   <= 1'b1;
                    else               r_depth <= r_depth - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign depth     = r_depth;
    assign err       = r_err;
    assign balanced  = (r_depth == '0) && !r_err;

endmodule
